or1200_dcpu_arb: RTL and testbench

Two-master arbiter that shares the data-cache CPU port (dcpu_*) between the LSU (master 0) and an auxiliary requester (master 1, debug-unit/DMA memory access). It sits between the LSU and the data cache/DMMU. It locks the grant for the whole transaction, including retries, and routes responses only to the granted master. The LSU has priority, but a starvation counter guarantees master 1 forward progress.

---
 rtl/or1200_dcpu_arb.sv | 195 +++++++++++++++++++
 tb/tb_or1200_dcpu_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_dcpu_arb.sv
// or1200_dcpu_arb
//   Two-master arbiter for the data-cache CPU port. Master 0 is the LSU and
//   master 1 is an auxiliary requester (debug unit / DMA). The grant is locked
//   for a whole transaction, including retries, and responses are routed only
//   to the granted master. The LSU has priority. After STARVE_LIMIT LSU
//   completions while master 1 waits, master 1 wins the next arbitration.
//
//   Optional feature macro: OR1200_DCPU_ARB_TIMEOUT_EN
//     When it is defined, a watchdog ends a grant that has run for TIMEOUT
//     cycles with a bus error (tag OR1200_DTAG_BE) to the granted master.
//
// Ports
//   clk                           clock, rising edge
//   rst                           asynchronous reset, active low
//   m{0,1}_adr/cycstb/we/sel/dat  master request inputs
//   m{0,1}_ack/rty/err/tag_o      routed responses
//   m_dat_o                       read data, broadcast to both masters
//   dcpu_*_o                      request to the cache port
//   dcpu_*_i                      response from the cache port
module or1200_dcpu_arb #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_cycstb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_cycstb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic        m0_ack_o,
  output logic        m0_rty_o,
  output logic        m0_err_o,
  output logic [3:0]  m0_tag_o,
  output logic        m1_ack_o,
  output logic        m1_rty_o,
  output logic        m1_err_o,
  output logic [3:0]  m1_tag_o,
  output logic [31:0] m_dat_o,
  output logic [31:0] dcpu_adr_o,
  output logic        dcpu_cycstb_o,
  output logic        dcpu_we_o,
  output logic [3:0]  dcpu_sel_o,
  output logic [3:0]  dcpu_tag_o,
  output logic [31:0] dcpu_dat_o,
  input  logic [31:0] dcpu_dat_i,
  input  logic        dcpu_ack_i,
  input  logic        dcpu_rty_i,
  input  logic        dcpu_err_i,
  input  logic [3:0]  dcpu_tag_i
);

  localparam logic [3:0] OR1200_DTAG_IDLE = 4'h0;
  localparam logic [3:0] OR1200_DTAG_ND   = 4'h1;
  localparam logic [3:0] OR1200_DTAG_BE   = 4'hb;

  localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       gnt0, gnt1;
  logic       wd_fire;
  logic       done;

`ifdef OR1200_DCPU_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
  logic [7:0] wd_q, wd_d;

  assign wd_fire = (state_q != IDLE) && (wd_q == TIMEOUT_CNT);

  // Held at zero in IDLE so it starts from zero on every entry to GNTn.
  always_comb begin
    wd_d = wd_q;
    if (state_q == IDLE)
      wd_d = '0;
    else if (!dcpu_ack_i && !dcpu_err_i && !wd_fire)
      wd_d = wd_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign done = dcpu_ack_i | dcpu_err_i | wd_fire;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A transaction completing in its grant cycle never locks the grant.
        if (gnt1 && !done)      state_d = GNT1;
        else if (gnt0 && !done) state_d = GNT0;
      end
      GNT0:    if (done || !m0_cycstb_i) state_d = IDLE;
      GNT1:    if (done || !m1_cycstb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!m1_cycstb_i || gnt1)
      starve_d = '0;
    else if (gnt0 && dcpu_ack_i && !wd_fire && starve_q != STARVE_MAX)
      starve_d = starve_q + 4'd1;
  end

  // Output logic: grant decode, request mux, response routing.
  // Grants are suppressed while reset is asserted so every dcpu_* output is
  // idle during reset even if a master keeps requesting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst) begin
          if (m1_cycstb_i && (!m0_cycstb_i || starve_q == STARVE_MAX))
            gnt1 = 1'b1;
          else if (m0_cycstb_i)
            gnt0 = 1'b1;
        end
      end
      GNT0:    gnt0 = 1'b1;
      GNT1:    gnt1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dcpu_adr_o    = '0;
    dcpu_cycstb_o = 1'b0;
    dcpu_we_o     = 1'b0;
    dcpu_sel_o    = '0;
    dcpu_dat_o    = '0;
    if (gnt0) begin
      dcpu_adr_o    = m0_adr_i;
      dcpu_cycstb_o = m0_cycstb_i & ~wd_fire;
      dcpu_we_o     = m0_we_i;
      dcpu_sel_o    = m0_sel_i;
      dcpu_dat_o    = m0_dat_i;
    end else if (gnt1) begin
      dcpu_adr_o    = m1_adr_i;
      dcpu_cycstb_o = m1_cycstb_i & ~wd_fire;
      dcpu_we_o     = m1_we_i;
      dcpu_sel_o    = m1_sel_i;
      dcpu_dat_o    = m1_dat_i;
    end
    dcpu_tag_o = dcpu_cycstb_o ? OR1200_DTAG_ND : OR1200_DTAG_IDLE;
  end

  always_comb begin
    m0_ack_o = gnt0 & dcpu_ack_i & ~wd_fire;
    m0_rty_o = gnt0 & dcpu_rty_i & ~wd_fire;
    m0_err_o = gnt0 & (dcpu_err_i | wd_fire);
    m0_tag_o = OR1200_DTAG_IDLE;
    if (gnt0) m0_tag_o = wd_fire ? OR1200_DTAG_BE : dcpu_tag_i;
    m1_ack_o = gnt1 & dcpu_ack_i & ~wd_fire;
    m1_rty_o = gnt1 & dcpu_rty_i & ~wd_fire;
    m1_err_o = gnt1 & (dcpu_err_i | wd_fire);
    m1_tag_o = OR1200_DTAG_IDLE;
    if (gnt1) m1_tag_o = wd_fire ? OR1200_DTAG_BE : dcpu_tag_i;
    m_dat_o  = dcpu_dat_i;
  end

endmodule

// File: tb/tb_or1200_dcpu_arb.sv
module tb_or1200_dcpu_arb;

  localparam logic [3:0] TAG_IDLE = 4'h0;
  localparam logic [3:0] TAG_ND   = 4'h1;
  localparam logic [3:0] TAG_BE   = 4'hb;
`ifdef OR1200_DCPU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk, rst;
  logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
  logic        m0_cycstb_i, m1_cycstb_i, m0_we_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_rty_o, m0_err_o, m1_ack_o, m1_rty_o, m1_err_o;
  logic [3:0]  m0_tag_o, m1_tag_o;
  logic [31:0] m_dat_o, dcpu_adr_o, dcpu_dat_o, dcpu_dat_i;
  logic        dcpu_cycstb_o, dcpu_we_o;
  logic [3:0]  dcpu_sel_o, dcpu_tag_o, dcpu_tag_i;
  logic        dcpu_ack_i, dcpu_rty_i, dcpu_err_i;

  int n_chk = 0;
  int n_err = 0;

  or1200_dcpu_arb #(.STARVE_LIMIT(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_cycstb_i(m0_cycstb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m1_adr_i(m1_adr_i), .m1_cycstb_i(m1_cycstb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m0_ack_o(m0_ack_o), .m0_rty_o(m0_rty_o), .m0_err_o(m0_err_o), .m0_tag_o(m0_tag_o),
    .m1_ack_o(m1_ack_o), .m1_rty_o(m1_rty_o), .m1_err_o(m1_err_o), .m1_tag_o(m1_tag_o),
    .m_dat_o(m_dat_o),
    .dcpu_adr_o(dcpu_adr_o), .dcpu_cycstb_o(dcpu_cycstb_o), .dcpu_we_o(dcpu_we_o),
    .dcpu_sel_o(dcpu_sel_o), .dcpu_tag_o(dcpu_tag_o), .dcpu_dat_o(dcpu_dat_o),
    .dcpu_dat_i(dcpu_dat_i), .dcpu_ack_i(dcpu_ack_i), .dcpu_rty_i(dcpu_rty_i),
    .dcpu_err_i(dcpu_err_i), .dcpu_tag_i(dcpu_tag_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
    m0_cycstb_i = 1'b1; m1_cycstb_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_sel_i = 4'hf; m1_sel_i = '0;
    dcpu_dat_i = '0; dcpu_ack_i = 1'b0; dcpu_rty_i = 1'b0; dcpu_err_i = 1'b0;
    dcpu_tag_i = TAG_IDLE;
    #2;
    // Reset values, even with m0 requesting
    chk("rst_cycstb", dcpu_cycstb_o, 1'b0);
    chk("rst_adr",    dcpu_adr_o, 32'h0);
    chk("rst_sel",    dcpu_sel_o, 4'h0);
    chk("rst_dtag",   dcpu_tag_o, TAG_IDLE);
    chk("rst_m0_ack", m0_ack_o, 1'b0);
    chk("rst_m1_err", m1_err_o, 1'b0);
    chk("rst_m0_tag", m0_tag_o, TAG_IDLE);
    chk("rst_m1_tag", m1_tag_o, TAG_IDLE);
    tick;
    m0_cycstb_i = 1'b0;
    rst = 1'b1;
    tick;

    // m0 read of 0x100, ack two cycles later
    m0_cycstb_i = 1'b1; m0_adr_i = 32'h100;
    #1;
    chk("t1_adr",    dcpu_adr_o, 32'h100);
    chk("t1_cycstb", dcpu_cycstb_o, 1'b1);
    chk("t1_dtag",   dcpu_tag_o, TAG_ND);
    chk("t1_sel",    dcpu_sel_o, 4'hf);
    chk("t1_m1_tag", m1_tag_o, TAG_IDLE);
    tick;
    chk("t1_adr_wait", dcpu_adr_o, 32'h100);
    chk("t1_m0_ack_wait", m0_ack_o, 1'b0);
    tick;
    dcpu_ack_i = 1'b1; dcpu_tag_i = TAG_ND; dcpu_dat_i = 32'hdeadbeef;
    #1;
    chk("t1_m0_ack", m0_ack_o, 1'b1);
    chk("t1_m0_tag", m0_tag_o, TAG_ND);
    chk("t1_dat",    m_dat_o, 32'hdeadbeef);
    chk("t1_m1_ack", m1_ack_o, 1'b0);
    chk("t1_m1_tag_ack", m1_tag_o, TAG_IDLE);
    tick;
    dcpu_ack_i = 1'b0; dcpu_tag_i = TAG_IDLE; m0_cycstb_i = 1'b0;
    #1;
    chk("t1_idle_cycstb", dcpu_cycstb_o, 1'b0);
    tick;

    // Starvation: both request, m1 wins after the 4th m0 ack
    m0_cycstb_i = 1'b1; m0_adr_i = 32'hA0;
    m1_cycstb_i = 1'b1; m1_adr_i = 32'hA1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_gnt_m0", dcpu_adr_o, 32'hA0);
      tick;
      dcpu_ack_i = 1'b1;
      #1;
      chk("t2_m0_ack", m0_ack_o, 1'b1);
      chk("t2_m1_ack", m1_ack_o, 1'b0);
      tick;
      dcpu_ack_i = 1'b0;
    end
    #1;
    chk("t2_gnt_m1", dcpu_adr_o, 32'hA1);
    dcpu_ack_i = 1'b1;
    #1;
    chk("t2_m1_ack_done", m1_ack_o, 1'b1);
    chk("t2_m0_ack_none", m0_ack_o, 1'b0);
    tick;
    dcpu_ack_i = 1'b0;
    #1;
    chk("t2_back_m0", dcpu_adr_o, 32'hA0);
    m0_cycstb_i = 1'b0; m1_cycstb_i = 1'b0;
    tick;

    // m1 granted with retries; m0 request must wait for m1's ack
    m1_cycstb_i = 1'b1; m1_adr_i = 32'h200; m1_we_i = 1'b1; m1_dat_i = 32'h12345678;
    #1;
    chk("t3_adr", dcpu_adr_o, 32'h200);
    chk("t3_we",  dcpu_we_o, 1'b1);
    chk("t3_dat", dcpu_dat_o, 32'h12345678);
    tick;
    dcpu_rty_i = 1'b1; dcpu_tag_i = TAG_ND;
    #1;
    chk("t3_m1_rty", m1_rty_o, 1'b1);
    chk("t3_m0_rty", m0_rty_o, 1'b0);
    tick;
    m0_cycstb_i = 1'b1; m0_adr_i = 32'h300;
    #1;
    chk("t3_lock_adr", dcpu_adr_o, 32'h200);
    chk("t3_m1_tag",   m1_tag_o, TAG_ND);
    chk("t3_m0_tag",   m0_tag_o, TAG_IDLE);
    tick;
    #1;
    chk("t3_lock_adr3", dcpu_adr_o, 32'h200);
    tick;
    dcpu_rty_i = 1'b0; dcpu_ack_i = 1'b1;
    #1;
    chk("t3_m1_ack", m1_ack_o, 1'b1);
    chk("t3_m0_ack", m0_ack_o, 1'b0);
    tick;
    dcpu_ack_i = 1'b0; dcpu_tag_i = TAG_IDLE; m1_cycstb_i = 1'b0; m1_we_i = 1'b0;
    #1;
    chk("t3_m0_fwd", dcpu_adr_o, 32'h300);
    chk("t3_m0_cyc", dcpu_cycstb_o, 1'b1);
    tick;
    m0_cycstb_i = 1'b0;
    tick;

    // m0 aborts; pending m1 granted on the next IDLE cycle
    m0_cycstb_i = 1'b1; m0_adr_i = 32'h400;
    m1_cycstb_i = 1'b1; m1_adr_i = 32'h500;
    #1;
    chk("t4_gnt_m0", dcpu_adr_o, 32'h400);
    tick;
    m0_cycstb_i = 1'b0;
    #1;
    chk("t4_abort_cyc", dcpu_cycstb_o, 1'b0);
    tick;
    #1;
    chk("t4_gnt_m1", dcpu_adr_o, 32'h500);
    chk("t4_m1_cyc", dcpu_cycstb_o, 1'b1);
    tick;

    // Reset asserted while in GNT1
    #1;
    chk("t5_gnt1_cyc", dcpu_cycstb_o, 1'b1);
    rst = 1'b0;
    m0_cycstb_i = 1'b1; m0_adr_i = 32'h600;
    #1;
    chk("t5_rst_cyc", dcpu_cycstb_o, 1'b0);
    chk("t5_rst_adr", dcpu_adr_o, 32'h0);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_idle_gnt_m0", dcpu_adr_o, 32'h600);
    chk("t5_idle_cyc", dcpu_cycstb_o, 1'b1);
    m0_cycstb_i = 1'b0; m1_cycstb_i = 1'b0;
    tick;

    // Error routed to m1 only
    m1_cycstb_i = 1'b1; m1_adr_i = 32'h800;
    tick;
    dcpu_err_i = 1'b1;
    #1;
    chk("t6_m1_err", m1_err_o, 1'b1);
    chk("t6_m0_err", m0_err_o, 1'b0);
    tick;
    dcpu_err_i = 1'b0; m1_cycstb_i = 1'b0;
    #1;
    chk("t6_idle", dcpu_cycstb_o, 1'b0);
    tick;

`ifdef OR1200_DCPU_ARB_TIMEOUT_EN
    // Watchdog: no response, error after TO cycles in GNT0
    m0_cycstb_i = 1'b1; m0_adr_i = 32'h700;
    tick;
    for (int i = 0; i < TO; i++) begin
      #1;
      chk("t7_no_err", m0_err_o, 1'b0);
      tick;
    end
    #1;
    chk("t7_err",    m0_err_o, 1'b1);
    chk("t7_tag",    m0_tag_o, TAG_BE);
    chk("t7_cyc",    dcpu_cycstb_o, 1'b0);
    chk("t7_m1_err", m1_err_o, 1'b0);
    tick;
    #1;
    chk("t7_err_clr", m0_err_o, 1'b0);
    chk("t7_regnt",   dcpu_cycstb_o, 1'b1);
    m0_cycstb_i = 1'b0;
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
